// File: rtl/bcd_convert_seq_if.sv
// Handshake bundle for bcd_convert_seq: binary value in, packed BCD digits plus
// an error flag and a leading-zero blanking mask out.
interface bcd_convert_seq_if #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      num;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_code;
    logic                  err;
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output in_valid, num, out_ready,
        input  in_ready, out_valid, bcd_code, err, blank_mask
    );

    modport slave (
        input  in_valid, num, out_ready,
        output in_ready, out_valid, bcd_code, err, blank_mask
    );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter using double-dabble, one input bit per clock,
// with fixed BIN_W-cycle latency and registered results held until taken.
module bcd_convert_seq #(
    parameter int         BIN_W   = 7,
    parameter int         DIGITS  = 2,
    parameter int         MAX_VAL = 81,
    parameter logic [3:0] ERR_NIB = 4'hB
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_convert_seq_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_NUM = BIN_W'(MAX_VAL);

    if ((MAX_VAL >= (2 ** BIN_W)) || (MAX_VAL > ((10 ** DIGITS) - 1))) begin : g_param_check
        $error("bcd_convert_seq: MAX_VAL does not fit BIN_W or DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               range_err_q, range_err_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               err_q, err_d;
    logic [DIGITS-1:0]  mask_q, mask_d;

    logic [ACC_W-1:0]   adj;
    logic [ACC_W-1:0]   step_acc;
    logic [DIGITS-1:0]  result_mask;
    logic               zero_run;
    logic               in_ready;

    // Ready is suppressed while reset is asserted, not just after it.
    assign in_ready = (state_q == IDLE) && rst_n;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        range_err_d = range_err_q;
        out_valid_d = out_valid_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        mask_d      = mask_q;

        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        step_acc = {adj[ACC_W-2:0], shift_q[BIN_W-1]};

        // A digit is blanked only if it and every digit above it are zero.
        zero_run    = 1'b1;
        result_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run       = zero_run & (step_acc[4*i +: 4] == 4'd0);
            result_mask[i] = zero_run;
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    shift_d     = bus.num;
                    acc_d       = '0;
                    cnt_d       = CNT_W'(BIN_W);
                    range_err_d = (bus.num > MAX_NUM);
                    state_d     = CONV;
                end
            end
            CONV: begin
                acc_d   = step_acc;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    if (range_err_q) begin
                        bcd_d  = {DIGITS{ERR_NIB}};
                        err_d  = 1'b1;
                        mask_d = '0;
                    end else begin
                        bcd_d  = step_acc;
                        err_d  = 1'b0;
                        mask_d = result_mask;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            range_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            range_err_q <= range_err_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            mask_q      <= mask_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.bcd_code   = bcd_q;
    assign bus.err        = err_q;
    assign bus.blank_mask = mask_q;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed bench for bcd_convert_seq: a default 7-bit/2-digit instance and a
// 10-bit/3-digit instance sharing one clock and reset.
module tb_bcd_convert_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       useWide  = 1'b0;
    logic       inValid  = 1'b0;
    logic       outReady = 1'b0;
    logic [9:0] numDrive = '0;

    bcd_convert_seq_if #(.BIN_W(7),  .DIGITS(2)) n_if ();
    bcd_convert_seq_if #(.BIN_W(10), .DIGITS(3)) w_if ();

    assign n_if.in_valid  = inValid && !useWide;
    assign n_if.num       = numDrive[6:0];
    assign n_if.out_ready = outReady && !useWide;
    assign w_if.in_valid  = inValid && useWide;
    assign w_if.num       = numDrive;
    assign w_if.out_ready = outReady && useWide;

    bcd_convert_seq #(.BIN_W(7), .DIGITS(2), .MAX_VAL(81), .ERR_NIB(4'hB)) dutNarrow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (n_if.slave)
    );

    bcd_convert_seq #(.BIN_W(10), .DIGITS(3), .MAX_VAL(999), .ERR_NIB(4'hB)) dutWide (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w_if.slave)
    );

    logic [31:0] selCode, selMask, selValid, selReady, selErr;
    always_comb begin
        if (useWide) begin
            selCode  = 32'(w_if.bcd_code);
            selMask  = 32'(w_if.blank_mask);
            selValid = 32'(w_if.out_valid);
            selReady = 32'(w_if.in_ready);
            selErr   = 32'(w_if.err);
        end else begin
            selCode  = 32'(n_if.bcd_code);
            selMask  = 32'(n_if.blank_mask);
            selValid = 32'(n_if.out_valid);
            selReady = 32'(n_if.in_ready);
            selErr   = 32'(n_if.err);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; returns how many rising edges passed before out_valid.
    task automatic waitResult(input string tag, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (selValid == 32'd1) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) checkOutput({tag, " result timeout"}, 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input string tag, input int value, input int stall,
                                 input int expCode, input int expErr, input int expMask, input int expLat);
        int lat;
        outReady = (stall == 0);
        checkOutput({tag, " in_ready idle"}, selReady, 32'd1);
        numDrive = 10'(value);
        inValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput({tag, " in_ready busy"}, selReady, 32'd0);
        waitResult(tag, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " bcd_code"}, selCode, 32'(expCode));
        checkOutput({tag, " err"}, selErr, 32'(expErr));
        checkOutput({tag, " blank_mask"}, selMask, 32'(expMask));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " held code"}, selCode, 32'(expCode));
            checkOutput({tag, " held valid"}, selValid, 32'd1);
            checkOutput({tag, " held in_ready"}, selReady, 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, " valid after take"}, selValid, 32'd0);
        checkOutput({tag, " ready after take"}, selReady, 32'd1);
        checkOutput({tag, " code kept"}, selCode, 32'(expCode));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit sawValid;

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", selValid, 32'd0);
        checkOutput("reset in_ready", selReady, 32'd0);
        checkOutput("reset bcd_code", selCode, 32'd0);
        checkOutput("reset err", selErr, 32'd0);
        checkOutput("reset blank_mask", selMask, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] default instance conversions");
        applyStimulus("n0",   0,   0, 'h00, 0, 'b10, 7);
        applyStimulus("n81",  81,  0, 'h81, 0, 'b00, 7);
        applyStimulus("n9",   9,   0, 'h09, 0, 'b10, 7);
        applyStimulus("n82",  82,  0, 'hBB, 1, 'b00, 7);
        applyStimulus("n127", 127, 0, 'hBB, 1, 'b00, 7);
        applyStimulus("n37",  37,  2, 'h37, 0, 'b00, 7);

        $display("[TB] back-pressure with a pending input");
        outReady = 1'b0;
        numDrive = 10'd45;
        inValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        numDrive = 10'd12;
        checkOutput("bp in_ready conv", selReady, 32'd0);
        waitResult("bp45", lat);
        checkOutput("bp45 latency", 32'(lat), 32'd7);
        checkOutput("bp45 bcd_code", selCode, 32'h45);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp45 held code", selCode, 32'h45);
            checkOutput("bp45 held valid", selValid, 32'd1);
            checkOutput("bp45 held in_ready", selReady, 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("bp45 valid after take", selValid, 32'd0);
        checkOutput("bp45 ready after take", selReady, 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("bp12 accepted", selReady, 32'd0);
        waitResult("bp12", lat);
        checkOutput("bp12 latency", 32'(lat), 32'd7);
        checkOutput("bp12 bcd_code", selCode, 32'h12);
        checkOutput("bp12 blank_mask", selMask, 32'b00);
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("bp12 valid after take", selValid, 32'd0);

        $display("[TB] reset during conversion");
        numDrive = 10'd66;
        inValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", selValid, 32'd0);
        checkOutput("midreset bcd_code", selCode, 32'd0);
        checkOutput("midreset in_ready", selReady, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset ready after release", selReady, 32'd1);
        @(negedge clk);
        sawValid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (selValid != 32'd0) sawValid = 1'b1;
        end
        checkOutput("midreset no result", 32'(sawValid), 32'd0);
        applyStimulus("n66", 66, 0, 'h66, 0, 'b00, 7);

        $display("[TB] wide instance conversions");
        useWide = 1'b1;
        @(negedge clk);
        applyStimulus("w999",  999,  0, 'h999, 0, 'b000, 10);
        applyStimulus("w5",    5,    0, 'h005, 0, 'b110, 10);
        applyStimulus("w1000", 1000, 0, 'hBBB, 1, 'b000, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
